// File: rtl/cv32e40x_aes_rng_buffer_if.sv
// Mask-word handshake between the RNG buffer (master) and the masked AES unit (slave).
// Each accepted word supplies one shareB byte and the 36 DOM refresh bits.
interface cv32e40x_aes_rng_buffer_if;
  logic        rnd_valid_o;
  logic        rnd_ready_i;
  logic [7:0]  shareB_o;
  logic [35:0] randombits_o;

  modport master (
    output rnd_valid_o,
    output shareB_o,
    output randombits_o,
    input  rnd_ready_i
  );

  modport slave (
    input  rnd_valid_o,
    input  shareB_o,
    input  randombits_o,
    output rnd_ready_i
  );
endinterface

// File: rtl/cv32e40x_aes_rng_buffer.sv
// xorshift64 PRNG feeding a small FIFO of 44-bit mask words for the masked AES datapath.
// The state only advances on a push, so every buffered word is a fresh PRNG output.
module cv32e40x_aes_rng_buffer #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [63:0] SEED_DEFAULT = 64'h0000_0000_0000_0001
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       seed_valid_i,
  input  logic [63:0]                seed_i,
  cv32e40x_aes_rng_buffer_if.master  rnd_if,
  output logic [$clog2(DEPTH):0]     fill_level_o,
  output logic [15:0]                words_served_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned FW = PW + 1;
  localparam logic [63:0] SEED_ZERO_SUB = 64'h9E37_79B9_7F4A_7C15;

  logic [63:0]   r_state;
  logic [43:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [FW-1:0] r_fill;
  logic [15:0]   r_served;

  logic [63:0]   w_nxt;
  logic [63:0]   w_t0;
  logic [63:0]   w_t1;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [43:0]   w_head;

  assign w_t0  = r_state ^ (r_state << 13);
  assign w_t1  = w_t0 ^ (w_t0 >> 7);
  assign w_nxt = w_t1 ^ (w_t1 << 17);

  assign w_valid = (r_fill != '0);
  assign w_pop   = w_valid && rnd_if.rnd_ready_i;
  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign w_push  = (r_fill < FW'(DEPTH)) || w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= SEED_DEFAULT;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_served <= '0;
    end else begin
      if (w_pop && (r_served != 16'hFFFF)) begin
        r_served <= r_served + 16'd1;
      end
      if (seed_valid_i) begin
        r_state  <= (seed_i == 64'd0) ? SEED_ZERO_SUB : seed_i;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_fill   <= '0;
      end else begin
        if (w_push) begin
          r_state  <= w_nxt;
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_fill <= r_fill + FW'(1);
          2'b01:   r_fill <= r_fill - FW'(1);
          default: r_fill <= r_fill;
        endcase
      end
    end
  end

  // Storage needs no reset: the occupancy counter gates everything read out of it.
  always_ff @(posedge clk) begin
    if (!reset && !seed_valid_i && w_push) begin
      r_mem[r_wr_ptr] <= w_nxt[43:0];
    end
  end

  assign w_head = w_valid ? r_mem[r_rd_ptr] : 44'd0;

  assign rnd_if.rnd_valid_o  = w_valid;
  assign rnd_if.shareB_o     = w_head[7:0];
  assign rnd_if.randombits_o = w_head[43:8];
  assign fill_level_o        = r_fill;
  assign words_served_o      = r_served;

endmodule

// File: tb/tb_cv32e40x_aes_rng_buffer.sv
// Directed plus randomized bench for the AES RNG buffer against a queue-based reference model.
module tb_cv32e40x_aes_rng_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        seed_valid_i = 1'b0;
  logic [63:0] seed_i = 64'd0;
  logic [2:0]  fill_level_o;
  logic [15:0] words_served_o;

  cv32e40x_aes_rng_buffer_if rnd_if ();

  cv32e40x_aes_rng_buffer #(.DEPTH(DEPTH), .SEED_DEFAULT(64'h1)) dut (
    .clk            (clk),
    .reset          (reset),
    .seed_valid_i   (seed_valid_i),
    .seed_i         (seed_i),
    .rnd_if         (rnd_if.master),
    .fill_level_o   (fill_level_o),
    .words_served_o (words_served_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_state;
  logic [43:0] m_q[$];
  logic [15:0] m_cnt;
  bit          m_seen[logic [43:0]];

  function automatic logic [63:0] nxt(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [43:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 44'd0;
    chk("valid", 64'(rnd_if.rnd_valid_o), 64'(m_q.size() > 0));
    chk("shareB", 64'(rnd_if.shareB_o), 64'(head[7:0]));
    chk("randombits", 64'(rnd_if.randombits_o), 64'(head[43:8]));
    chk("fill", 64'(fill_level_o), 64'(m_q.size()));
    chk("served", 64'(words_served_o), 64'(m_cnt));
  endtask

  // One clock: drive inputs, advance the reference model by the behavioural rules, compare.
  task automatic cyc(input logic rst, input logic sv, input logic [63:0] sd, input logic rdy);
    bit pop;
    logic [43:0] w;
    reset = rst;
    seed_valid_i = sv;
    seed_i = sd;
    rnd_if.rnd_ready_i = rdy;
    pop = (m_q.size() > 0) && rdy;
    @(posedge clk);
    if (rst) begin
      m_state = 64'h1;
      m_q.delete();
      m_cnt = 16'd0;
      m_seen.delete();
    end else begin
      if (pop) begin
        w = m_q.pop_front();
        checks++;
        assert (!m_seen.exists(w)) else begin
          errors++;
          $error("FAIL dup observed=%0h expected=fresh", w);
        end
        m_seen[w] = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (sv) begin
        m_state = (sd == 64'd0) ? 64'h9E37_79B9_7F4A_7C15 : sd;
        m_q.delete();
        m_seen.delete();
      end else if (m_q.size() < DEPTH) begin
        m_state = nxt(m_state);
        m_q.push_back(m_state[43:0]);
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    int n;
    rnd_if.rnd_ready_i = 1'b0;
    m_state = 64'h1;
    m_cnt = 16'd0;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk("rst_valid", 64'(rnd_if.rnd_valid_o), 64'd0);
    chk("rst_fill", 64'(fill_level_o), 64'd0);

    // Test 1: first word and fill-up
    cyc(0, 0, 0, 0);
    chk("first_shareB", 64'(rnd_if.shareB_o), 64'h41);
    chk("first_rbits", 64'(rnd_if.randombits_o), 64'h0_0040_8220);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("full_fill", 64'(fill_level_o), 64'd4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("hold_shareB", 64'(rnd_if.shareB_o), 64'h41);

    // Test 2: streaming pops at full occupancy
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
    chk("stream_fill", 64'(fill_level_o), 64'd4);
    chk("stream_served", 64'(words_served_o), 64'd10);

    // Test 3: reseed with three words buffered
    cyc(0, 1, 64'h5, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("pre_seed_fill", 64'(fill_level_o), 64'd3);
    cyc(0, 1, 64'h1, 0);
    chk("seed_fill", 64'(fill_level_o), 64'd0);
    chk("seed_valid", 64'(rnd_if.rnd_valid_o), 64'd0);
    cyc(0, 0, 0, 0);
    chk("seed_head", {rnd_if.randombits_o, rnd_if.shareB_o}, 64'h000_4082_2041);

    // Test 4: zero seed substitution
    cyc(0, 1, 64'h0, 0);
    cyc(0, 0, 0, 0);
    chk("zero_seed_head", {rnd_if.randombits_o, rnd_if.shareB_o},
        64'(nxt(64'h9E37_79B9_7F4A_7C15) & 64'hFFF_FFFF_FFFF));

    // Test 5: ready while empty, then saturation of the served counter
    cyc(0, 1, 64'h1234_5678_9ABC_DEF0, 1);
    n = m_cnt;
    cyc(0, 0, 0, 1);
    chk("empty_ready", 64'(words_served_o), 64'(n));
    n = 0;
    while (m_cnt != 16'hFFFE && n < 70000) begin
      cyc(0, 0, 0, 1);
      n++;
    end
    chk("reach_fffe", 64'(words_served_o), 64'hFFFE);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    chk("saturate", 64'(words_served_o), 64'hFFFF);

    // Test 6: reset mid-stream with two words buffered
    cyc(0, 1, 64'h77, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("mid_fill", 64'(fill_level_o), 64'd2);
    cyc(1, 0, 0, 0);
    chk("mid_rst_fill", 64'(fill_level_o), 64'd0);
    chk("mid_rst_served", 64'(words_served_o), 64'd0);
    cyc(0, 0, 0, 0);
    chk("restart_head", {rnd_if.randombits_o, rnd_if.shareB_o}, 64'h000_4082_2041);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      logic r_rst, r_sv, r_rdy;
      logic [63:0] r_sd;
      r_rst = ($urandom_range(0, 99) == 0);
      r_sv  = ($urandom_range(0, 19) == 0);
      r_rdy = $urandom_range(0, 1);
      r_sd  = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      cyc(r_rst, r_sv, r_sd, r_rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cv32e40x_aes_rng_buffer.md
Name: cv32e40x_aes_rng_buffer

Overview:
Upstream randomness supplier for the masked AES unit (DOM S-box datapath). It holds a 64-bit xorshift64 PRNG, seedable from software or a TRNG, and buffers generated words in a small FIFO. Each word provides one 8-bit mask share (shareB) and 36 refresh bits (randombits) per saes32 operation. The consumer pops one word per issued AES op via a valid/ready handshake, so no mask is ever reused.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
SEED_DEFAULT, 64'h0000_0000_0000_0001, PRNG state loaded at reset; must be nonzero.

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
seed_valid_i  input  1  load seed_i into PRNG and flush FIFO
seed_i  input  64  new PRNG seed
rnd_ready_i  input  1  consumer accepts current word (AES op issued)
rnd_valid_o  output  1  FIFO non-empty; head word valid
shareB_o  output  8  head word bits [7:0]
randombits_o  output  36  head word bits [43:8]
fill_level_o  output  $clog2(DEPTH)+1  current FIFO occupancy
words_served_o  output  16  saturating count of popped words

Behaviour:
- Reset (sync, active-high): state <= SEED_DEFAULT; FIFO empty; fill_level_o=0; rnd_valid_o=0; words_served_o=0. shareB_o/randombits_o read 0 while empty.
- PRNG step nxt(x): t=x^(x<<13); t=t^(t>>7); t=t^(t<<17). All shifts are logical and 64-bit.
- Generation: in each non-reset, non-seed cycle where push is allowed, state <= nxt(state) and nxt(state)[43:0] is written at the FIFO tail. The state does not advance when no push occurs.
- Push allowed when fill < DEPTH, or when fill == DEPTH and a pop occurs in the same cycle.
- Pop: rnd_valid_o && rnd_ready_i. The head advances, and words_served_o increments and saturates at 16'hFFFF. rnd_ready_i while empty is ignored; no count change.
- Simultaneous push and pop: fill unchanged, both pointers advance.
- Latency: the first word is visible the cycle after reset deasserts; the FIFO is full DEPTH cycles after reset when nothing is popped. Head data is registered (FIFO storage), with no combinational path from rnd_ready_i to outputs.
- Pointers: log2(DEPTH)-bit, wrapping modulo DEPTH. Occupancy is tracked by a separate counter ranging 0..DEPTH.
- Reseed (seed_valid_i=1 at an edge):
  - state <= (seed_i==0) ? 64'h9E37_79B9_7F4A_7C15 : seed_i
  - FIFO flushed: pointers=0, fill=0; no push that cycle.
  - Next cycle rnd_valid_o=0; the first post-seed word appears one cycle later, i.e. 2 cycles after the seed edge.
  - A pop in the same cycle as seed_valid_i counts in words_served_o. The word was consumed by the AES unit that cycle.
  - Reseed takes priority over push.
- Reset takes priority over everything; reset mid-fill discards all buffered words.
- Security: no word is presented twice. After a flush, no pre-flush word is ever output.

Test Plan:
1. Release reset with SEED_DEFAULT=1 and rnd_ready_i=0 -> cycle 1: rnd_valid_o=1, shareB_o=8'h41, randombits_o=36'h0_0040_8220 (first word 44'h000_4082_2041); fill_level_o reaches 4 after 4 cycles, then holds with state frozen.
2. Full FIFO; hold rnd_ready_i=1 for 10 cycles -> one pop per cycle; fill_level_o stays 4; words_served_o=10. The output sequence equals a reference xorshift64 model, low 44 bits, with no duplicates.
3. seed_valid_i=1, seed_i=1, with FIFO holding 3 words -> next cycle fill_level_o=0 and rnd_valid_o=0; the cycle after, head = 44'h000_4082_2041.
4. seed_valid_i=1, seed_i=0 -> state loads 64'h9E37_79B9_7F4A_7C15; the first word equals nxt(that value)[43:0] from the model.
5. Empty FIFO right after a seed, rnd_ready_i=1 -> no pop; words_served_o unchanged. Preload the counter to 16'hFFFE, then pop 3 words -> counter saturates at 16'hFFFF.
6. Assert reset mid-stream with fill=2 -> next cycle fill_level_o=0, rnd_valid_o=0, words_served_o=0; the word sequence restarts from SEED_DEFAULT.
